// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and default widths for the framebuffer write path
package fb_pkg;

  localparam int FB_ADDR_W = 10;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, DRAIN, CLR_WAIT, CLEAR} fb_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, first-word-fall-through, push and pop may coincide at any fill
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop && !empty;
  // a pop frees the head slot in the same edge, so a full FIFO can still take a push
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// rtl/fb_write_sched.sv - queues tile writes and issues them, or a full-screen clear, only during vblank
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int NWORDS     = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              resetB,
  input  logic              vblank,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] clr_val,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ovf
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NWORDS - 1);

  fb_state_t                  state;
  logic                       ready_en;
  logic                       clr_busy;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [ADDR_W+DATA_W-1:0]   pop_data;
  logic [ADDR_W:0]            cnt;
  logic [DATA_W-1:0]          clr_val_q;

  // blocking new writes while a clear is owed keeps queued writes ahead of the sweep
  assign clr_busy = (state == CLR_WAIT) || (state == CLEAR);
  assign wr_ready = ready_en && !full && !clr_busy;
  assign push     = wr_valid && wr_ready;
  assign pop      = vblank && !empty;
  assign busy     = !empty || clr_busy;

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetB),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state     <= IDLE;
      ready_en  <= 1'b0;
      cnt       <= '0;
      clr_val_q <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      ovf       <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      we       <= 1'b0;
      if (pop) begin
        we             <= 1'b1;
        {waddr, wdata} <= pop_data;
      end else if (state == CLEAR && vblank) begin
        we    <= 1'b1;
        waddr <= cnt[ADDR_W-1:0];
        wdata <= clr_val_q;
        cnt   <= cnt + 1'b1;
      end
      if (clr_req && clr_busy) ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (clr_req) begin
            clr_val_q <= clr_val;
            state     <= CLR_WAIT;
          end else if (!empty) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (clr_req) begin
            clr_val_q <= clr_val;
            state     <= CLR_WAIT;
          end else if (empty) begin
            state <= IDLE;
          end
        end
        CLR_WAIT: begin
          if (empty) begin
            cnt   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          if (vblank && cnt == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// tb/tb_fb_write_sched.sv - directed self-checking bench for fb_write_sched
module tb_fb_write_sched;
  import fb_pkg::*;

  logic       clk = 1'b0;
  logic       resetB;
  logic       vblank;
  logic       wr_valid;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       clr_req;
  logic [7:0] clr_val;
  logic       we;
  logic [9:0] waddr;
  logic [7:0] wdata;
  logic       busy;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  fb_write_sched dut (
    .clk      (clk),
    .resetB   (resetB),
    .vblank   (vblank),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .clr_val  (clr_val),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetB   = 1'b0;
    vblank   = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    clr_val  = '0;
    step();
    step();
    resetB = 1'b1;
    step();
  endtask

  task automatic test_reset();
    resetB   = 1'b0;
    vblank   = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 10'h3FF;
    wr_data  = 8'hFF;
    clr_req  = 1'b0;
    clr_val  = '0;
    step();
    step();
    n_tests++;
    if ({we, waddr, wdata, wr_ready, busy, ovf} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_vals: we=%b waddr=%h wdata=%h rdy=%b busy=%b ovf=%b, want all 0",
               we, waddr, wdata, wr_ready, busy, ovf);
    end
    wr_valid = 1'b0;
    resetB   = 1'b1;
    step();
    n_tests++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: wr_ready=%b busy=%b, want 1 0", wr_ready, busy);
    end
  endtask

  task automatic test_latency();
    do_reset();
    vblank   = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 10'h005;
    wr_data  = 8'h3C;
    step();
    wr_valid = 1'b0;
    n_tests++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_accept_edge: we=%b, want 0", we);
    end
    step();
    n_tests++;
    if (we !== 1'b1 || waddr !== 10'h005 || wdata !== 8'h3C || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_write: we=%b waddr=%h wdata=%h busy=%b, want 1 005 3c 0",
               we, waddr, wdata, busy);
    end
    step();
    n_tests++;
    if (we !== 1'b0 || waddr !== 10'h005 || wdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL lat_hold: we=%b waddr=%h wdata=%h, want 0 005 3c", we, waddr, wdata);
    end
  endtask

  task automatic test_full();
    fb_entry_t vec [8];
    int errs;
    for (int i = 0; i < 8; i++) begin
      vec[i].addr = 10'(10'h100 + i * 3);
      vec[i].data = 8'(8'hA0 + i);
    end
    do_reset();
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_addr  = vec[i].addr;
      wr_data  = vec[i].data;
      if (wr_ready !== 1'b1) errs++;
      step();
      if (we !== 1'b0) errs++;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL full_fill: %0d cycles with wr_ready=0 or we=1, want 0", errs);
    end
    wr_addr = 10'h3AB;
    wr_data = 8'h99;
    n_tests++;
    if (wr_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ninth: wr_ready=%b busy=%b, want 0 1", wr_ready, busy);
    end
    step();
    n_tests++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_we: we=%b, want 0", we);
    end
    wr_valid = 1'b0;
    vblank   = 1'b1;
    errs     = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (we !== 1'b1 || waddr !== vec[i].addr || wdata !== vec[i].data) begin
        errs++;
        $display("FAIL full_drain_%0d: we=%b waddr=%h wdata=%h, want 1 %h %h",
                 i, we, waddr, wdata, vec[i].addr, vec[i].data);
      end
    end
    n_tests++;
    if (errs != 0) n_fail++;
    step();
    n_tests++;
    if (we !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after: we=%b busy=%b, want 0 0", we, busy);
    end
  endtask

  task automatic test_vblank_gating();
    int k;
    int errs;
    logic vb;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 10'(10'h020 + i);
      wr_data  = 8'(8'h50 + i);
      step();
    end
    wr_valid = 1'b0;
    k    = 0;
    errs = 0;
    for (int c = 0; c < 16; c++) begin
      vb     = (c % 4 == 0);
      vblank = vb;
      step();
      if (vb) begin
        if (we !== 1'b1 || waddr !== 10'(10'h020 + k) || wdata !== 8'(8'h50 + k)) errs++;
        k++;
      end else if (we !== 1'b0) begin
        errs++;
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL vblank_gate: %0d bad cycles, want 0", errs);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL vblank_gate_done: busy=%b, want 0", busy);
    end
    vblank = 1'b0;
  endtask

  task automatic test_clear();
    int exp_a;
    int errs;
    int rdy_errs;
    logic started;
    do_reset();
    vblank   = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 10'h010;
    wr_data  = 8'hAA;
    step();
    wr_valid = 1'b0;
    clr_req  = 1'b1;
    clr_val  = 8'h00;
    step();
    clr_req = 1'b0;
    clr_val = 8'hEE;
    n_tests++;
    if (we !== 1'b1 || waddr !== 10'h010 || wdata !== 8'hAA) begin
      n_fail++;
      $display("FAIL clr_first_write: we=%b waddr=%h wdata=%h, want 1 010 aa", we, waddr, wdata);
    end
    exp_a    = 0;
    errs     = 0;
    rdy_errs = 0;
    started  = 1'b0;
    for (int c = 0; c < 1100 && exp_a < 1024; c++) begin
      wr_valid = 1'b1;
      if (wr_ready !== 1'b0) rdy_errs++;
      step();
      if (we === 1'b1) begin
        started = 1'b1;
        if (waddr !== 10'(exp_a) || wdata !== 8'h00) errs++;
        exp_a++;
      end else if (started) begin
        errs++;
      end
    end
    wr_valid = 1'b0;
    n_tests++;
    if (exp_a != 1024 || errs != 0) begin
      n_fail++;
      $display("FAIL clr_sweep: writes=%0d bad=%0d, want 1024 0", exp_a, errs);
    end
    n_tests++;
    if (rdy_errs != 0) begin
      n_fail++;
      $display("FAIL clr_ready_low: %0d cycles with wr_ready=1, want 0", rdy_errs);
    end
    n_tests++;
    if (waddr !== 10'h3FF || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_last: waddr=%h ovf=%b, want 3ff 0", waddr, ovf);
    end
    step();
    n_tests++;
    if (we !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_end: we=%b busy=%b wr_ready=%b, want 0 0 1", we, busy, wr_ready);
    end
  endtask

  task automatic test_ovf();
    int exp_a;
    int errs;
    do_reset();
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_init: ovf=%b, want 0", ovf);
    end
    vblank  = 1'b1;
    clr_req = 1'b1;
    clr_val = 8'h5A;
    step();
    clr_req = 1'b0;
    exp_a   = 0;
    errs    = 0;
    for (int c = 0; c < 1100 && exp_a < 1024; c++) begin
      clr_req = (exp_a == 100);
      clr_val = (exp_a == 100) ? 8'hFF : 8'h5A;
      step();
      if (we === 1'b1) begin
        if (waddr !== 10'(exp_a) || wdata !== 8'h5A) errs++;
        exp_a++;
      end
    end
    clr_req = 1'b0;
    n_tests++;
    if (exp_a != 1024 || errs != 0 || waddr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL ovf_sweep: writes=%0d bad=%0d last=%h, want 1024 0 3ff", exp_a, errs, waddr);
    end
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b, want 1", ovf);
    end
    step();
    step();
    n_tests++;
    if (we !== 1'b0 || busy !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after: we=%b busy=%b ovf=%b, want 0 0 1", we, busy, ovf);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic found;
    int   n_we;
    do_reset();
    vblank  = 1'b1;
    clr_req = 1'b1;
    clr_val = 8'h77;
    step();
    clr_req = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 1100 && !found; c++) begin
      step();
      if (we === 1'b1 && waddr === 10'h200) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_mid_reach: write to 200 not seen, want seen");
    end
    resetB = 1'b0;
    #1;
    n_tests++;
    if (we !== 1'b0 || waddr !== 10'h000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: we=%b waddr=%h busy=%b, want 0 000 0", we, waddr, busy);
    end
    step();
    step();
    resetB = 1'b1;
    n_we   = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (we !== 1'b0) n_we++;
    end
    n_tests++;
    if (n_we != 0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_after: writes=%0d busy=%b wr_ready=%b, want 0 0 1",
               n_we, busy, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_vblank_gating();
    test_clear();
    test_ovf();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
